// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the load/store sequencer: FSM states, func3 codes,
// fault causes and the size/alignment legality helpers.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // func3 encodings, also consumed by the core decoder
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    // Unsigned variants make no sense for stores, so they are rejected there
    function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
        logic illegal;
        case (f3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_BU, F3_HU:     illegal = is_store;
            default:          illegal = 1'b1;
        endcase
        return illegal;
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lane);
        logic mis;
        case (f3)
            F3_H, F3_HU: mis = lane[0];
            F3_W:        mis = |lane;
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Load data alignment: shifts the addressed bytes down to bit 0 and applies
// sign or zero extension according to func3. Purely combinational so the
// cache path can share it.
module mem_load_extend
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_lane,
    input  logic [2:0]  i_func3,
    output logic [31:0] o_data
);

    logic [31:0] w_shift;

    assign w_shift = i_rdata >> {i_lane, 3'b000};

    // Extend the low byte/halfword of the shifted word
    always_comb begin
        o_data = '0;
        case (i_func3)
            F3_B:    o_data = {{24{w_shift[7]}}, w_shift[7:0]};
            F3_H:    o_data = {{16{w_shift[15]}}, w_shift[15:0]};
            F3_W:    o_data = w_shift;
            F3_BU:   o_data = {24'd0, w_shift[7:0]};
            F3_HU:   o_data = {16'd0, w_shift[15:0]};
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: one bus transaction per memory instruction, with
// pipeline stall, lane enables, store replication, load extension and
// misaligned / illegal / timeout fault reporting.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        MemRW,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    // Last wait-counter value before giving up on the bus
    localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_wait_cnt;
    logic [2:0]  r_func3;
    logic [1:0]  r_lane;

    logic        w_illegal;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ext;

    assign w_illegal    = f3_illegal(MemRW, func3);
    assign w_misaligned = f3_misaligned(func3, addr[1:0]);

    // Issuing cycle is stalled too, so the core holds the instruction in place
    assign stall = ((r_state == ST_IDLE) && req_valid) || (r_state == ST_REQ);

    // Byte-lane enables and store-data replication for the incoming access
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = wdata;
        case (func3)
            F3_B, F3_BU: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                w_be    = 4'b0011 << {addr[1], 1'b0};
                w_wdata = {2{wdata[15:0]}};
            end
            F3_W:    w_be = 4'b1111;
            default: ;
        endcase
    end

    // Extension works from the latched lane/size, not the live inputs
    mem_load_extend u_load_extend (
        .i_rdata (bus_rdata),
        .i_lane  (r_lane),
        .i_func3 (r_func3),
        .o_data  (w_ext)
    );

    // Sequencer FSM with registered outputs; bus fields live only in REQ
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= '0;
            r_func3     <= '0;
            r_lane      <= '0;
            done        <= 1'b0;
            rdata       <= '0;
            fault       <= 1'b0;
            fault_cause <= CAUSE_NONE;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_be      <= '0;
            bus_wdata   <= '0;
        end else begin
            done        <= 1'b0;
            rdata       <= '0;
            fault       <= 1'b0;
            fault_cause <= CAUSE_NONE;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (w_illegal) begin
                            r_state     <= ST_ERR;
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_ILLEGAL;
                        end else if (w_misaligned) begin
                            r_state     <= ST_ERR;
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_MISALIGN;
                        end else begin
                            r_state    <= ST_REQ;
                            r_wait_cnt <= '0;
                            r_func3    <= func3;
                            r_lane     <= addr[1:0];
                            bus_req    <= 1'b1;
                            bus_we     <= MemRW;
                            bus_addr   <= {addr[31:2], 2'b00};
                            bus_be     <= w_be;
                            bus_wdata  <= w_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_ack || (r_wait_cnt == LP_WAIT_LAST)) begin
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= '0;
                        bus_be    <= '0;
                        bus_wdata <= '0;
                        if (bus_ack) begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                            rdata   <= bus_we ? 32'd0 : w_ext;
                        end else begin
                            r_state     <= ST_ERR;
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_TIMEOUT;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                ST_ERR:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: per-cycle comparison against a transaction-level
// timeline model, directed cases with literal results, then random traffic.
module tb_mem_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst, req_valid, MemRW, bus_ack;
    logic [2:0]  func3;
    logic [31:0] addr, wdata, bus_rdata;
    logic        stall, done, fault, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [1:0]  fault_cause;
    logic [3:0]  bus_be;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .MemRW(MemRW),
        .func3(func3), .addr(addr), .wdata(wdata), .stall(stall),
        .done(done), .rdata(rdata), .fault(fault), .fault_cause(fault_cause),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata)
    );

    // expected outputs for the current cycle
    logic        e_stall, e_done, e_fault, e_bus_req, e_bus_we;
    logic [31:0] e_rdata, e_bus_addr, e_bus_wdata;
    logic [3:0]  e_bus_be;
    logic [1:0]  e_cause;
    bit          chk_en = 1'b0;

    int checks = 0;
    int errors = 0;
    int n_done = 0, n_fault = 0, n_busreq = 0;
    logic [31:0] last_rdata, last_bwdata;
    logic [3:0]  last_be;
    logic [1:0]  last_cause;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit m_illegal(input bit we, input logic [2:0] f3);
        return (size_of(f3) == 0) || (we && f3[2]);
    endfunction

    function automatic bit m_misal(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a[1:0]) % size_of(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int sz = size_of(f3);
        int base = int'(a[1:0]) - (int'(a[1:0]) % sz);
        logic [3:0] be = '0;
        for (int i = 0; i < 4; i++) be[i] = (i >= base) && (i < base + sz);
        return be;
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
        int sz = size_of(f3);
        logic [31:0] o = '0;
        for (int i = 0; i < 4; i++) o[8*i +: 8] = wd[8*(i % sz) +: 8];
        return o;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int sz = size_of(f3);
        int off = int'(a[1:0]);
        longint v = 0;
        for (int k = sz - 1; k >= 0; k--) v = v * 256 + longint'(rd[8*(off+k) +: 8]);
        if ((f3 == 3'b000 || f3 == 3'b001) && v >= (longint'(1) << (8*sz - 1)))
            v = v - (longint'(1) << (8*sz));
        return 32'(v);
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 32'(stall), 32'(e_stall));
            chk("done", 32'(done), 32'(e_done));
            chk("rdata", rdata, e_rdata);
            chk("fault", 32'(fault), 32'(e_fault));
            chk("fault_cause", 32'(fault_cause), 32'(e_cause));
            chk("bus_req", 32'(bus_req), 32'(e_bus_req));
            chk("bus_we", 32'(bus_we), 32'(e_bus_we));
            chk("bus_addr", bus_addr, e_bus_addr);
            chk("bus_be", 32'(bus_be), 32'(e_bus_be));
            chk("bus_wdata", bus_wdata, e_bus_wdata);
            if (done)    begin n_done++;  last_rdata = rdata; end
            if (fault)   begin n_fault++; last_cause = fault_cause; end
            if (bus_req) begin n_busreq++; last_be = bus_be; last_bwdata = bus_wdata; end
        end
    end

    // ---------------- driver ----------------
    task automatic zero_exp();
        e_stall = 0; e_done = 0; e_fault = 0; e_bus_req = 0; e_bus_we = 0;
        e_rdata = 0; e_bus_addr = 0; e_bus_wdata = 0; e_bus_be = 0; e_cause = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_side();
        MemRW = 1'($urandom); func3 = 3'($urandom); addr = $urandom;
        wdata = $urandom; bus_rdata = $urandom;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            rst = 0; req_valid = 0; rand_side(); bus_ack = 1'($urandom);
            zero_exp();
        end
    endtask

    // w: REQ cycle index carrying the ack (>= TO means never);
    // rst_at: REQ cycle index where reset is asserted (-1 none)
    task automatic access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int w, input logic [31:0] rd,
                          input int rst_at);
        bit acked = 0;
        next_cycle();
        rst = 0; req_valid = 1; MemRW = we; func3 = f3; addr = a; wdata = wd;
        bus_ack = 1'($urandom); bus_rdata = $urandom;
        zero_exp(); e_stall = 1;
        if (m_illegal(we, f3) || m_misal(f3, a)) begin
            next_cycle();
            req_valid = 1'($urandom); rand_side(); bus_ack = 1'($urandom);
            zero_exp(); e_fault = 1;
            e_cause = m_illegal(we, f3) ? 2'b10 : 2'b01;
            return;
        end
        for (int j = 0; j < TO; j++) begin
            next_cycle();
            req_valid = 1'($urandom); rand_side();
            bus_ack = (j == w); bus_rdata = (j == w) ? rd : $urandom;
            rst = (j == rst_at);
            zero_exp(); e_stall = 1; e_bus_req = 1; e_bus_we = we;
            e_bus_addr = a & 32'hFFFF_FFFC; e_bus_be = m_be(f3, a);
            e_bus_wdata = m_wd(f3, wd);
            if (j == rst_at) begin
                next_cycle();
                rst = 0; req_valid = 0; rand_side(); bus_ack = 1;
                zero_exp();
                return;
            end
            if (j == w) begin acked = 1; break; end
        end
        next_cycle();
        req_valid = 1'($urandom); rand_side(); bus_ack = 1'($urandom);
        zero_exp();
        if (acked) begin
            e_done = 1; e_rdata = we ? 32'd0 : m_load(f3, a, rd);
        end else begin
            e_fault = 1; e_cause = 2'b11;
        end
    endtask

    int d0, f0, b0;
    task automatic snap();
        d0 = n_done; f0 = n_fault; b0 = n_busreq;
    endtask

    initial begin
        rst = 1; req_valid = 0; MemRW = 0; func3 = 0; addr = 0; wdata = 0;
        bus_ack = 0; bus_rdata = 0;
        zero_exp();
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); rst = 1; req_valid = 0; rand_side(); bus_ack = 1'($urandom); zero_exp();
        end
        idle_cycles(2);

        // LW 0x100, zero wait states
        snap();
        access(1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, -1);
        idle_cycles(1);
        chk("lw_rdata", last_rdata, 32'hDEADBEEF);
        chk("lw_be", 32'(last_be), 32'hF);
        chk("lw_busreq_cycles", 32'(n_busreq - b0), 32'd1);

        // byte/halfword extension cases
        access(1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_0000, -1);
        idle_cycles(1);
        chk("lb_rdata", last_rdata, 32'hFFFFFF80);
        access(1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF_0000, -1);
        idle_cycles(1);
        chk("lbu_rdata", last_rdata, 32'h00000080);
        access(1'b0, 3'b101, 32'h102, 32'h0, 2, 32'h80FF_0000, -1);
        idle_cycles(1);
        chk("lhu_rdata", last_rdata, 32'h000080FF);

        // SB with 3 wait states
        snap();
        access(1'b1, 3'b000, 32'h201, 32'h12345678, 3, 32'hFFFF_FFFF, -1);
        idle_cycles(1);
        chk("sb_be", 32'(last_be), 32'h2);
        chk("sb_wdata", last_bwdata, 32'h78787878);
        chk("sb_busreq_cycles", 32'(n_busreq - b0), 32'd4);
        chk("sb_done_pulses", 32'(n_done - d0), 32'd1);
        chk("sb_rdata", last_rdata, 32'h0);

        // misaligned and illegal
        snap();
        access(1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h0, -1);
        idle_cycles(1);
        chk("mis_cause", 32'(last_cause), 32'h1);
        chk("mis_busreq", 32'(n_busreq - b0), 32'd0);
        access(1'b1, 3'b100, 32'h0, 32'h0, 0, 32'h0, -1);
        idle_cycles(1);
        chk("ill_cause", 32'(last_cause), 32'h2);

        // timeout, then late acks during idle
        snap();
        access(1'b0, 3'b010, 32'h300, 32'h0, TO, 32'h0, -1);
        idle_cycles(3);
        chk("to_busreq_cycles", 32'(n_busreq - b0), 32'd4);
        chk("to_cause", 32'(last_cause), 32'h3);
        chk("to_no_done", 32'(n_done - d0), 32'd0);

        // reset in the second REQ cycle, then a normal LW
        snap();
        access(1'b0, 3'b010, 32'h400, 32'h0, TO, 32'h0, 1);
        idle_cycles(1);
        chk("rst_no_pulse", 32'((n_done - d0) + (n_fault - f0)), 32'd0);
        access(1'b0, 3'b010, 32'h404, 32'h0, 0, 32'hCAFEF00D, -1);
        idle_cycles(1);
        chk("post_rst_lw", last_rdata, 32'hCAFEF00D);

        // random traffic
        for (int t = 0; t < 300; t++) begin
            logic [2:0] f3;
            logic [31:0] a;
            int ra;
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010;
                    3: f3 = 3'b100; default: f3 = 3'b101;
                endcase
            end else f3 = 3'($urandom);
            a = $urandom;
            if ($urandom_range(0, 4) < 3) a = a & ~(32'(size_of(f3) == 4 ? 3 : (size_of(f3) == 2 ? 1 : 0)));
            ra = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, TO - 1)) : -1;
            access(1'($urandom), f3, a, $urandom, int'($urandom_range(0, TO)), $urandom, ra);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        @(posedge clk);
        #1;
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
